cp0_intr_ctrl: RTL and testbench

CP0_INTR_CTRL -- requirements
Module: cp0_intr_ctrl

---
 rtl/cp0_intr_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_cp0_intr_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_intr_ctrl.sv
// cp0_intr_ctrl: CP0 interrupt controller with edge-detected requests,
// fixed priority (highest channel index wins), a saved-PC/channel stack for
// nested handlers, and a small CP0 register window.
// Optional feature: define CP0_INTR_NEST_EN for DEPTH-level nesting with
// preemption by higher channels. Without it a single level is kept
// (one EPC) and a take requires an idle controller.
module cp0_intr_ctrl #(
    parameter int unsigned N_CH       = 3,
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] VEC_BASE   = 32'h400,
    parameter logic [31:0] VEC_STRIDE = 32'h200
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] irq_in,
    input  logic            take_ok,
    input  logic [31:0]     resume_pc,
    input  logic            eret,
    input  logic            mtc0_we,
    input  logic [4:0]      mtc0_addr,
    input  logic [31:0]     mtc0_data,
    input  logic [4:0]      mfc0_addr,
    output logic [31:0]     mfc0_data,
    output logic            irq_take,
    output logic [31:0]     irq_vector,
    output logic [31:0]     epc,
    output logic [3:0]      depth
);

    localparam logic [4:0] ADDR_CAUSE = 5'h0c;
    localparam logic [4:0] ADDR_PEND  = 5'h0d;
    localparam logic [4:0] ADDR_EPC   = 5'h0e;
    localparam logic [4:0] ADDR_DIS   = 5'h16;
    localparam logic [4:0] ADDR_MASK  = 5'h17;

`ifdef CP0_INTR_NEST_EN
    localparam int unsigned EFF_DEPTH = DEPTH;
`else
    // Single handler level: one EPC entry, no preemption possible.
    localparam int unsigned EFF_DEPTH = (DEPTH > 1) ? 1 : DEPTH;
`endif

    logic [N_CH-1:0] sync_q, prev_q, irq_edge;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] mask_q, mask_d;
    logic            dis_q, dis_d;
    logic [3:0]      depth_q, depth_d;
    logic [2:0]      active_ch_q, active_ch_d;
    logic [31:0]     stack_pc_q [EFF_DEPTH];
    logic [31:0]     stack_pc_d [EFF_DEPTH];
    logic [2:0]      stack_ch_q [EFF_DEPTH];
    logic [2:0]      stack_ch_d [EFF_DEPTH];
    logic            cand_valid;
    logic [2:0]      cand_ch;
    logic [31:0]     top_pc;
    logic [2:0]      top_ch;

    assign irq_edge = sync_q & ~prev_q;

    // Highest-index pending and enabled channel is the candidate.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        cand_valid = 1'b0;
        cand_ch    = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (pending_q[i] && mask_q[i]) begin
                cand_valid = 1'b1;
                cand_ch    = 3'(i);
            end
        end
    end

    // Top-of-stack entry (index depth-1); zero when the stack is empty.
    always_comb begin
        top_pc = '0;
        top_ch = '0;
        for (int unsigned i = 0; i < EFF_DEPTH; i++) begin
            if (depth_q == 4'(i + 1)) begin
                top_pc = stack_pc_q[i];
                top_ch = stack_ch_q[i];
            end
        end
    end

    // Take decision: eret always wins, full stack blocks, only higher channels preempt.
    always_comb begin
        irq_take = rst_n && cand_valid && !dis_q && take_ok && !eret
                   && (depth_q < 4'(EFF_DEPTH))
                   && ((depth_q == 4'd0) || (cand_ch > active_ch_q));
    end

    assign irq_vector = VEC_BASE + 32'(cand_ch) * VEC_STRIDE;
    assign epc        = top_pc;
    assign depth      = depth_q;

    // CP0 read port.
    always_comb begin
        mfc0_data = '0;
        case (mfc0_addr)
            ADDR_DIS:   mfc0_data = {31'b0, dis_q};
            ADDR_MASK:  mfc0_data = 32'(mask_q);
            ADDR_EPC:   mfc0_data = top_pc;
            ADDR_PEND:  mfc0_data = 32'(pending_q);
            ADDR_CAUSE: mfc0_data = {20'b0, depth_q, 5'b0, active_ch_q};
            default:    mfc0_data = '0;
        endcase
    end

    // Next state: CP0 writes first, then take/return, new edges last so set beats clear.
    always_comb begin
        pending_d   = pending_q;
        mask_d      = mask_q;
        dis_d       = dis_q;
        depth_d     = depth_q;
        active_ch_d = active_ch_q;
        stack_pc_d  = stack_pc_q;
        stack_ch_d  = stack_ch_q;

        if (mtc0_we) begin
            case (mtc0_addr)
                ADDR_DIS:  dis_d     = mtc0_data[0];
                ADDR_MASK: mask_d    = mtc0_data[N_CH-1:0];
                ADDR_PEND: pending_d = pending_q & ~mtc0_data[N_CH-1:0];
                ADDR_EPC: begin
                    for (int unsigned i = 0; i < EFF_DEPTH; i++) begin
                        if (depth_q == 4'(i + 1)) stack_pc_d[i] = mtc0_data;
                    end
                end
                default: ;
            endcase
        end

        if (irq_take) begin
            for (int unsigned i = 0; i < EFF_DEPTH; i++) begin
                if (depth_q == 4'(i)) begin
                    stack_pc_d[i] = resume_pc;
                    stack_ch_d[i] = active_ch_q;
                end
            end
            depth_d     = depth_q + 4'd1;
            active_ch_d = cand_ch;
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (cand_ch == 3'(i)) pending_d[i] = 1'b0;
            end
        end else if (eret && (depth_q != 4'd0)) begin
            depth_d     = depth_q - 4'd1;
            active_ch_d = top_ch;
        end

        pending_d = pending_d | irq_edge;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            sync_q      <= '0;
            prev_q      <= '0;
            pending_q   <= '0;
            mask_q      <= '1;
            dis_q       <= 1'b0;
            depth_q     <= '0;
            active_ch_q <= '0;
            // NOTE: the stack is small and a reset mid-handler must discard it, so it is reset.
            for (int unsigned i = 0; i < EFF_DEPTH; i++) begin
                stack_pc_q[i] <= '0;
                stack_ch_q[i] <= '0;
            end
        end else begin
            sync_q      <= irq_in;
            prev_q      <= sync_q;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            dis_q       <= dis_d;
            depth_q     <= depth_d;
            active_ch_q <= active_ch_d;
            stack_pc_q  <= stack_pc_d;
            stack_ch_q  <= stack_ch_d;
        end
    end

endmodule

// File: tb/tb_cp0_intr_ctrl.sv
// tb_cp0_intr_ctrl: table-driven bench for cp0_intr_ctrl. Five channels and
// DEPTH=4 so that a four-deep preemption chain plus one further, higher
// request can be exercised; channels 0..2 keep the default vectors.
// Expectations follow CP0_INTR_NEST_EN when it is defined for the build.
module tb_cp0_intr_ctrl;

    localparam int unsigned N_CH  = 5;
    localparam int unsigned DEPTH = 4;
`ifdef CP0_INTR_NEST_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] irq_in;
    logic            take_ok;
    logic [31:0]     resume_pc;
    logic            eret;
    logic            mtc0_we;
    logic [4:0]      mtc0_addr;
    logic [31:0]     mtc0_data;
    logic [4:0]      mfc0_addr;
    logic [31:0]     mfc0_data;
    logic            irq_take;
    logic [31:0]     irq_vector;
    logic [31:0]     epc;
    logic [3:0]      depth;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    cp0_intr_ctrl #(
        .N_CH      (N_CH),
        .DEPTH     (DEPTH),
        .VEC_BASE  (32'h400),
        .VEC_STRIDE(32'h200)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_in),
        .take_ok   (take_ok),
        .resume_pc (resume_pc),
        .eret      (eret),
        .mtc0_we   (mtc0_we),
        .mtc0_addr (mtc0_addr),
        .mtc0_data (mtc0_data),
        .mfc0_addr (mfc0_addr),
        .mfc0_data (mfc0_data),
        .irq_take  (irq_take),
        .irq_vector(irq_vector),
        .epc       (epc),
        .depth     (depth)
    );

    typedef struct {
        logic            rst;
        logic [N_CH-1:0] irq;
        logic            ok;
        logic            ret;
        logic [31:0]     pc;
        logic            we;
        logic [4:0]      wa;
        logic [31:0]     wd;
        logic [4:0]      ra;
        logic            x_take;
        logic [31:0]     x_vec;
        logic [31:0]     x_epc;
        logic [3:0]      x_depth;
        logic [31:0]     x_rd;
    } vec_t;

    typedef struct {
        int          id;
        logic        take;
        logic [31:0] vec;
        logic [31:0] epc;
        logic [3:0]  depth;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, input logic [N_CH-1:0] irq, input logic ok, input logic ret,
        input logic [31:0] pc, input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic [4:0] ra, input logic t, input logic [31:0] vec, input logic [31:0] e,
        input logic [3:0] d, input logic [31:0] rd);
        vec_t v;
        v.rst = rst; v.irq = irq; v.ok = ok; v.ret = ret; v.pc = pc;
        v.we = we; v.wa = wa; v.wd = wd; v.ra = ra;
        v.x_take = t; v.x_vec = vec; v.x_epc = e; v.x_depth = d; v.x_rd = rd;
        return v;
    endfunction

    task automatic check(input string what, input int id, input logic [31:0] act,
                         input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s step=%0d got=%h want=%h", what, id, act, want);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, queue its expectation,
    // then compare the settled combinational outputs before the rising edge.
    task automatic apply(input vec_t v, input int id);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst_n     = v.rst;
        irq_in    = v.irq;
        take_ok   = v.ok;
        eret      = v.ret;
        resume_pc = v.pc;
        mtc0_we   = v.we;
        mtc0_addr = v.wa;
        mtc0_data = v.wd;
        mfc0_addr = v.ra;
        e.id = id; e.take = v.x_take; e.vec = v.x_vec; e.epc = v.x_epc;
        e.depth = v.x_depth; e.rd = v.x_rd;
        sb.push_back(e);
        #2;
        got = sb.pop_front();
        check("irq_take", got.id, 32'(irq_take), 32'(got.take));
        if (got.take) check("irq_vector", got.id, irq_vector, got.vec);
        check("epc", got.id, epc, got.epc);
        check("depth", got.id, 32'(depth), 32'(got.depth));
        check("mfc0_data", got.id, mfc0_data, got.rd);
    endtask

    // Plain cycle: reset released, take_ok high, no CP0 write.
    task automatic cyc(input int id, input logic [N_CH-1:0] irq, input logic ret,
                       input logic [31:0] pc, input logic [4:0] ra, input logic t,
                       input logic [31:0] vec, input logic [31:0] e, input logic [3:0] d,
                       input logic [31:0] rd);
        apply(mk(1, irq, 1, ret, pc, 0, 5'h0, 32'h0, ra, t, vec, e, d, rd), id);
    endtask

    initial begin
        rst_n = 1'b0; irq_in = '0; take_ok = 1'b1; eret = 1'b0; resume_pc = '0;
        mtc0_we = 1'b0; mtc0_addr = '0; mtc0_data = '0; mfc0_addr = '0;
        repeat (2) @(posedge clk);

        // rst irq ok ret pc we wa wd ra | take vec epc depth rd
        tbl.push_back(mk(0, 5'h00, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h17, 0, 32'h0,   32'h0,    0, 32'h1f));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h16, 0, 32'h0,   32'h0,    0, 32'h0));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0c, 0, 32'h0,   32'h0,    0, 32'h0));
        // single request on ch1: take in the third cycle
        tbl.push_back(mk(1, 5'h02, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h0));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h0));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h100, 0, 5'h00, 32'h0, 5'h0d, 1, 32'h600, 32'h0,    0, 32'h2));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0c, 0, 32'h0,   32'h100,  1, 32'h101));
        tbl.push_back(mk(1, 5'h00, 1, 1, 32'h0,   0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,   32'h100,  1, 32'h0));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0c, 0, 32'h0,   32'h0,    0, 32'h0));
        // eret with empty stack is ignored
        tbl.push_back(mk(1, 5'h00, 1, 1, 32'h0,   0, 5'h00, 32'h0, 5'h0c, 0, 32'h0,   32'h0,    0, 32'h0));
        // ch0 and ch2 together: ch2 first, ch0 after eret
        tbl.push_back(mk(1, 5'h05, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h0));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h0));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h200, 0, 5'h00, 32'h0, 5'h0d, 1, 32'h800, 32'h0,    0, 32'h5));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,   32'h200,  1, 32'h1));
        tbl.push_back(mk(1, 5'h00, 1, 1, 32'h0,   0, 5'h00, 32'h0, 5'h0c, 0, 32'h0,   32'h200,  1, 32'h102));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h300, 0, 5'h00, 32'h0, 5'h0c, 1, 32'h400, 32'h0,    0, 32'h0));
        tbl.push_back(mk(1, 5'h00, 1, 1, 32'h0,   0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,   32'h300,  1, 32'h0));
        // mask 0b00101 hides ch1; W1C clears it
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   1, 5'h17, 32'h5, 5'h17, 0, 32'h0,   32'h0,    0, 32'h1f));
        tbl.push_back(mk(1, 5'h02, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h17, 0, 32'h0,   32'h0,    0, 32'h5));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h0));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h2));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   1, 5'h0d, 32'h2, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h2));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h0));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   1, 5'h17, 32'h1f, 5'h0d, 0, 32'h0,  32'h0,    0, 32'h0));
        // global disable, then take_ok low
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   1, 5'h16, 32'h1, 5'h16, 0, 32'h0,   32'h0,    0, 32'h0));
        tbl.push_back(mk(1, 5'h01, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h16, 0, 32'h0,   32'h0,    0, 32'h1));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h0));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h1));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   1, 5'h16, 32'h0, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h1));
        tbl.push_back(mk(1, 5'h00, 0, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h1));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h500, 0, 5'h00, 32'h0, 5'h0d, 1, 32'h400, 32'h0,    0, 32'h1));
        // EPC rewrite, unmapped address
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   1, 5'h0e, 32'h1234, 5'h0e, 0, 32'h0, 32'h500, 1, 32'h500));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0e, 0, 32'h0,   32'h1234, 1, 32'h1234));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   1, 5'h01, 32'hffffffff, 5'h01, 0, 32'h0, 32'h1234, 1, 32'h0));
        // same-cycle clear and new edge: set wins
        tbl.push_back(mk(1, 5'h00, 1, 1, 32'h0,   1, 5'h16, 32'h1, 5'h0e, 0, 32'h0,   32'h1234, 1, 32'h1234));
        tbl.push_back(mk(1, 5'h02, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h0));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h0));
        tbl.push_back(mk(1, 5'h02, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h2));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   1, 5'h0d, 32'h2, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h2));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   1, 5'h0d, 32'h2, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h2));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h0));
        // two edges on ch0 while pending merge into one take
        tbl.push_back(mk(1, 5'h01, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h0));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h0));
        tbl.push_back(mk(1, 5'h01, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h1));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h1));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   1, 5'h16, 32'h0, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h1));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h600, 0, 5'h00, 32'h0, 5'h0d, 1, 32'h400, 32'h0,    0, 32'h1));
        tbl.push_back(mk(1, 5'h00, 1, 1, 32'h0,   0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,   32'h600,  1, 32'h0));
        tbl.push_back(mk(1, 5'h00, 1, 0, 32'h0,   0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,   32'h0,    0, 32'h0));

        foreach (tbl[i]) apply(tbl[i], i);

        // Preemption: ch0 handler (resume 0x100) interrupted by ch2 (resume 0x420).
        cyc(101, 5'h01, 0, 32'h0,   5'h0d, 0, 32'h0,   32'h0,   0, 32'h0);
        cyc(102, 5'h00, 0, 32'h0,   5'h0d, 0, 32'h0,   32'h0,   0, 32'h0);
        cyc(103, 5'h00, 0, 32'h100, 5'h0d, 1, 32'h400, 32'h0,   0, 32'h1);
        cyc(104, 5'h04, 0, 32'h0,   5'h0d, 0, 32'h0,   32'h100, 1, 32'h0);
        cyc(105, 5'h00, 0, 32'h0,   5'h0d, 0, 32'h0,   32'h100, 1, 32'h0);
        cyc(106, 5'h00, 0, 32'h420, 5'h0d, NEST, 32'h800, 32'h100, 1, 32'h4);
        cyc(107, 5'h00, 0, 32'h0,   5'h0c, 0, 32'h0,
            NEST ? 32'h420 : 32'h100, NEST ? 4'd2 : 4'd1, NEST ? 32'h202 : 32'h100);
        cyc(108, 5'h00, 1, 32'h0,   5'h0d, 0, 32'h0,
            NEST ? 32'h420 : 32'h100, NEST ? 4'd2 : 4'd1, NEST ? 32'h0 : 32'h4);
        cyc(109, 5'h00, 0, 32'h700, 5'h0c, !NEST, 32'h800,
            NEST ? 32'h100 : 32'h0, NEST ? 4'd1 : 4'd0, NEST ? 32'h100 : 32'h0);
        cyc(110, 5'h00, 1, 32'h0,   5'h0d, 0, 32'h0,   NEST ? 32'h100 : 32'h700, 1, 32'h0);
        cyc(111, 5'h00, 0, 32'h0,   5'h0d, 0, 32'h0,   32'h0,   0, 32'h0);

        // Lower channel waits in ch2 handler; eret beats the candidate, take follows.
        cyc(201, 5'h04, 0, 32'h0,   5'h0d, 0, 32'h0,   32'h0,   0, 32'h0);
        cyc(202, 5'h00, 0, 32'h0,   5'h0d, 0, 32'h0,   32'h0,   0, 32'h0);
        cyc(203, 5'h00, 0, 32'h900, 5'h0d, 1, 32'h800, 32'h0,   0, 32'h4);
        cyc(204, 5'h02, 0, 32'h0,   5'h0d, 0, 32'h0,   32'h900, 1, 32'h0);
        cyc(205, 5'h00, 0, 32'h0,   5'h0d, 0, 32'h0,   32'h900, 1, 32'h0);
        cyc(206, 5'h00, 0, 32'h0,   5'h0d, 0, 32'h0,   32'h900, 1, 32'h2);
        cyc(207, 5'h00, 1, 32'h0,   5'h0d, 0, 32'h0,   32'h900, 1, 32'h2);
        cyc(208, 5'h00, 0, 32'ha00, 5'h0d, 1, 32'h600, 32'h0,   0, 32'h2);
        cyc(209, 5'h00, 1, 32'h0,   5'h0d, 0, 32'h0,   32'ha00, 1, 32'h0);
        cyc(210, 5'h00, 0, 32'h0,   5'h0d, 0, 32'h0,   32'h0,   0, 32'h0);

        // Fill the stack ch0->ch1->ch2->ch3, ch4 then blocked; reset discards all.
        cyc(301, 5'h01, 0, 32'h0,   5'h0d, 0, 32'h0,   32'h0,   0, 32'h0);
        cyc(302, 5'h00, 0, 32'h0,   5'h0d, 0, 32'h0,   32'h0,   0, 32'h0);
        cyc(303, 5'h00, 0, 32'h10,  5'h0d, 1, 32'h400, 32'h0,   0, 32'h1);
        cyc(304, 5'h02, 0, 32'h0,   5'h0d, 0, 32'h0,   32'h10,  1, 32'h0);
        cyc(305, 5'h00, 0, 32'h0,   5'h0d, 0, 32'h0,   32'h10,  1, 32'h0);
        cyc(306, 5'h00, 0, 32'h20,  5'h0d, NEST, 32'h600, 32'h10, 1, 32'h2);
        cyc(307, 5'h04, 0, 32'h0,   5'h0d, 0, 32'h0,
            NEST ? 32'h20 : 32'h10, NEST ? 4'd2 : 4'd1, NEST ? 32'h0 : 32'h2);
        cyc(308, 5'h00, 0, 32'h0,   5'h0d, 0, 32'h0,
            NEST ? 32'h20 : 32'h10, NEST ? 4'd2 : 4'd1, NEST ? 32'h0 : 32'h2);
        cyc(309, 5'h00, 0, 32'h30,  5'h0d, NEST, 32'h800,
            NEST ? 32'h20 : 32'h10, NEST ? 4'd2 : 4'd1, NEST ? 32'h4 : 32'h6);
        cyc(310, 5'h08, 0, 32'h0,   5'h0d, 0, 32'h0,
            NEST ? 32'h30 : 32'h10, NEST ? 4'd3 : 4'd1, NEST ? 32'h0 : 32'h6);
        cyc(311, 5'h00, 0, 32'h0,   5'h0d, 0, 32'h0,
            NEST ? 32'h30 : 32'h10, NEST ? 4'd3 : 4'd1, NEST ? 32'h0 : 32'h6);
        cyc(312, 5'h00, 0, 32'h40,  5'h0d, NEST, 32'ha00,
            NEST ? 32'h30 : 32'h10, NEST ? 4'd3 : 4'd1, NEST ? 32'h8 : 32'he);
        cyc(313, 5'h10, 0, 32'h0,   5'h0d, 0, 32'h0,
            NEST ? 32'h40 : 32'h10, NEST ? 4'd4 : 4'd1, NEST ? 32'h0 : 32'he);
        cyc(314, 5'h00, 0, 32'h0,   5'h0d, 0, 32'h0,
            NEST ? 32'h40 : 32'h10, NEST ? 4'd4 : 4'd1, NEST ? 32'h0 : 32'he);
        cyc(315, 5'h00, 0, 32'h50,  5'h0d, 0, 32'h0,
            NEST ? 32'h40 : 32'h10, NEST ? 4'd4 : 4'd1, NEST ? 32'h10 : 32'h1e);
        apply(mk(0, 5'h00, 1, 0, 32'h0, 0, 5'h00, 32'h0, 5'h0d, 0, 32'h0,
                 NEST ? 32'h40 : 32'h10, NEST ? 4'd4 : 4'd1, NEST ? 32'h10 : 32'h1e), 316);
        cyc(317, 5'h00, 0, 32'h0,   5'h0d, 0, 32'h0,   32'h0,   0, 32'h0);
        cyc(318, 5'h00, 0, 32'h0,   5'h0c, 0, 32'h0,   32'h0,   0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
